alu_ctrl_decoder: RTL and testbench
===================================

// Module: alu_ctrl_decoder
// PURPOSE
//  Decode stage that drives the ALU control inputs (FnClass, add_sub, ConstVar, LogicFn, ShiftFn, y-operand select).
//  Accepts 32-bit instruction words over a valid/ready handshake and emits one registered control bundle per instruction.
//  Sits between fetch and the ALU operand/execute stage; has a 2-entry skid buffer so in_ready is a pure flop output.
// PARAMETERS
//  IMM_W      16   immediate field width (instr[IMM_W-1:0]); result always extended to 32 bits
//  SKID_DEPTH 2    output buffer entries (fixed at 2; any other value is a compile-time $error)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  flush      in   1   synchronous: drop all buffered entries this cycle
//  in_valid   in   1   instr valid
//  in_ready   out  1   space available (registered)
//  in_instr   in   32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct, [15:0] imm
//  out_valid  out  1   control bundle valid
//  out_ready  in   1   execute stage accepts bundle
//  FnClass    out  3   000 LUI,001 SLT,010 SGT,011 ADD/SUB,100 LOGIC,101 SHIFT,110 HAM
//  add_sub    out  1   1 = subtract (SUB/SUBI/DEC/SLT/SGT)
//  ConstVar   out  1   1 = shift amount from register y, 0 = from imm[4:0]
//  LogicFn    out  2   00 AND,01 OR,10 XOR,11 NOR (NOT = NOR with imm 0)
//  ShiftFn    out  2   00 SLL,01 SRL,10 SRA
//  use_imm    out  1   1 = y operand is imm_val
//  imm_val    out  32  extended immediate
//  illegal    out  1   undefined opcode/funct; all other controls 0
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, every control output 0, buffers empty, counters 0.
//  Transfer on valid&&ready at rising edge, both ports. Accepted instr appears on out_* next cycle (latency 1) if buffer was empty.
//  Buffer: count 0..2. in_ready = (count<2), registered. Simultaneous push+pop at count 2 impossible (in_ready=0);
//   at count 1 or 2 pop-only decrements; push+pop keeps count; order strictly FIFO; outputs stable while out_valid&&!out_ready.
//  flush: count->0, out_valid->0, in_ready->1 next cycle; push in same cycle as flush is discarded.
//  Opcode 0x00 (R-type, funct): 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SGT,8 SLL,9 SRL,10 SRA,11 HAM; use_imm=0, ConstVar=1.
//  I-type opcodes: 01 ADDI,02 SUBI,03 ANDI,04 ORI,05 XORI,06 NOT,07 SLTI,08 SGTI,09 SLLI,0A SRLI,0B SRAI,0C LUI,0D INC,0E DEC; use_imm=1.
//  Immediate: sign-extend for ADDI/SUBI/SLTI/SGTI; zero-extend for ANDI/ORI/XORI/LUI; SLLI/SRLI/SRAI imm_val={27'b0,imm[4:0]}, ConstVar=0;
//   INC/DEC imm_val=1; NOT imm_val=0, LogicFn=11.
//  Other opcodes or funct>11: illegal=1, FnClass=000, use_imm=0, imm_val=0; entry still occupies buffer and handshakes normally.
//  Reset mid-operation: immediate return to reset state regardless of clk; buffered entries lost.
// CONFIGURATION
//  ALU_DEC_ILLEGAL_CNT_EN defined: extra port illegal_cnt out 16 = saturating count (stops at 0xFFFF) of illegal entries
//   popped (out_valid&&out_ready&&illegal); cleared only by rst_n, not by flush.
//  Undefined: no illegal_cnt port, no counter logic; all other behaviour identical.
// TESTING
//  ADD R-type 0x00000000, out_ready=1 -> next cycle out_valid=1, FnClass=011, add_sub=0, use_imm=0, illegal=0.
//  ADDI imm=0xFFFB -> imm_val=0xFFFFFFFB, add_sub=0; ANDI imm=0xFFFB -> imm_val=0x0000FFFB, FnClass=100, LogicFn=00.
//  SRAI imm=0x0024 -> FnClass=101, ShiftFn=10, ConstVar=0, imm_val=4; SRA R-type -> ConstVar=1, use_imm=0.
//  out_ready=0, push 3 instrs back-to-back -> 2 accepted, in_ready=0 on third; release -> popped in order, bundle stable while stalled.
//  Buffer full + flush -> next cycle out_valid=0, in_ready=1; asserting rst_n=0 mid-stream -> all outputs 0 without clock edge.
//  Opcode 0x3F and R-type funct 12, both popped -> illegal=1 each; with ALU_DEC_ILLEGAL_CNT_EN illegal_cnt=2; saturation at 0xFFFF held.

Source files
------------

// File: rtl/alu_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decoder
//
// Decode stage in front of the ALU. Each accepted 32-bit instruction word is
// decoded into one ALU control bundle: function class, add/subtract select,
// shift-amount source, logic/shift function, y-operand select, extended
// immediate and an illegal flag. Bundles are queued in a 2-entry skid buffer.
// in_ready is a flop, so the upstream ready path is registered.
//
// Optional feature (compile-time macro ALU_DEC_ILLEGAL_CNT_EN):
//   When defined, the illegal_cnt port is added. It is a saturating count of
//   illegal bundles handed to the execute stage. Only rst_n clears it; flush
//   leaves it unchanged. When undefined, neither the port nor the counter
//   exists.
//
// Parameters
//   IMM_W       immediate field width, taken from instr[IMM_W-1:0] (6..31)
//   SKID_DEPTH  output buffer entries; only the value 2 is supported
//
// Ports
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   flush       in   1   synchronous drop of all buffered bundles
//   in_valid    in   1   instruction valid
//   in_ready    out  1   buffer has space (registered)
//   in_instr    in   32  [31:26] opcode, [5:0] funct, [IMM_W-1:0] immediate
//   out_valid   out  1   control bundle valid
//   out_ready   in   1   execute stage accepts the bundle
//   FnClass     out  3   000 LUI,001 SLT,010 SGT,011 ADD/SUB,100 LOGIC,101 SHIFT,110 HAM
//   add_sub     out  1   1 = subtract
//   ConstVar    out  1   1 = shift amount from register y, 0 = from immediate
//   LogicFn     out  2   00 AND,01 OR,10 XOR,11 NOR
//   ShiftFn     out  2   00 SLL,01 SRL,10 SRA
//   use_imm     out  1   1 = y operand is imm_val
//   imm_val     out  32  extended immediate
//   illegal     out  1   undefined opcode/funct (all other controls 0)
//   illegal_cnt out  16  (ALU_DEC_ILLEGAL_CNT_EN only) saturating illegal count
// -----------------------------------------------------------------------------
module alu_ctrl_decoder #(
    parameter int IMM_W      = 16,
    parameter int SKID_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  FnClass,
    output logic        add_sub,
    output logic        ConstVar,
    output logic [1:0]  LogicFn,
    output logic [1:0]  ShiftFn,
    output logic        use_imm,
    output logic [31:0] imm_val,
    output logic        illegal
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    ,
    output logic [15:0] illegal_cnt
`endif
);

    // Elaboration-time parameter checks
    generate
        if (SKID_DEPTH != 2) begin : g_bad_depth
            $error("alu_ctrl_decoder: SKID_DEPTH must be 2");
        end
        if ((IMM_W < 6) || (IMM_W > 31)) begin : g_bad_imm_w
            $error("alu_ctrl_decoder: IMM_W must be in 6..31");
        end
    endgenerate

    // Function class encodings
    localparam logic [2:0] FC_LUI   = 3'b000;
    localparam logic [2:0] FC_SLT   = 3'b001;
    localparam logic [2:0] FC_SGT   = 3'b010;
    localparam logic [2:0] FC_ADD   = 3'b011;
    localparam logic [2:0] FC_LOGIC = 3'b100;
    localparam logic [2:0] FC_SHIFT = 3'b101;
    localparam logic [2:0] FC_HAM   = 3'b110;

    localparam logic [1:0] LF_AND = 2'b00;
    localparam logic [1:0] LF_OR  = 2'b01;
    localparam logic [1:0] LF_XOR = 2'b10;
    localparam logic [1:0] LF_NOR = 2'b11;

    localparam logic [1:0] SF_SLL = 2'b00;
    localparam logic [1:0] SF_SRL = 2'b01;
    localparam logic [1:0] SF_SRA = 2'b10;

    // One decoded control bundle; this is what a buffer entry holds
    typedef struct packed {
        logic [2:0]  fn_class;
        logic        add_sub;
        logic        const_var;
        logic [1:0]  logic_fn;
        logic [1:0]  shift_fn;
        logic        use_imm;
        logic [31:0] imm_val;
        logic        illegal;
    } ctrl_t;

    localparam int    CTRL_W    = $bits(ctrl_t);
    localparam ctrl_t CTRL_NONE = ctrl_t'({CTRL_W{1'b0}});

    // Instruction word -> control bundle
    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t            d;
        logic [5:0]       op;
        logic [5:0]       fn;
        logic [IMM_W-1:0] imm;
        logic [31:0]      sext;
        logic [31:0]      zext;
        d    = CTRL_NONE;
        op   = instr[31:26];
        fn   = instr[5:0];
        imm  = instr[IMM_W-1:0];
        sext = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
        zext = {{(32-IMM_W){1'b0}}, imm};
        case (op)
            6'h00: begin
                // R-type: y operand and shift amount both come from register y
                d.const_var = 1'b1;
                case (fn)
                    6'd0:  d.fn_class = FC_ADD;
                    6'd1:  begin d.fn_class = FC_ADD;   d.add_sub  = 1'b1;   end
                    6'd2:  begin d.fn_class = FC_LOGIC; d.logic_fn = LF_AND; end
                    6'd3:  begin d.fn_class = FC_LOGIC; d.logic_fn = LF_OR;  end
                    6'd4:  begin d.fn_class = FC_LOGIC; d.logic_fn = LF_XOR; end
                    6'd5:  begin d.fn_class = FC_LOGIC; d.logic_fn = LF_NOR; end
                    6'd6:  begin d.fn_class = FC_SLT;   d.add_sub  = 1'b1;   end
                    6'd7:  begin d.fn_class = FC_SGT;   d.add_sub  = 1'b1;   end
                    6'd8:  begin d.fn_class = FC_SHIFT; d.shift_fn = SF_SLL; end
                    6'd9:  begin d.fn_class = FC_SHIFT; d.shift_fn = SF_SRL; end
                    6'd10: begin d.fn_class = FC_SHIFT; d.shift_fn = SF_SRA; end
                    6'd11: d.fn_class = FC_HAM;
                    default: begin
                        d         = CTRL_NONE;
                        d.illegal = 1'b1;
                    end
                endcase
            end
            6'h01: begin d.fn_class = FC_ADD; d.use_imm = 1'b1; d.imm_val = sext; end
            6'h02: begin
                d.fn_class = FC_ADD; d.add_sub = 1'b1; d.use_imm = 1'b1; d.imm_val = sext;
            end
            6'h03: begin
                d.fn_class = FC_LOGIC; d.logic_fn = LF_AND; d.use_imm = 1'b1; d.imm_val = zext;
            end
            6'h04: begin
                d.fn_class = FC_LOGIC; d.logic_fn = LF_OR; d.use_imm = 1'b1; d.imm_val = zext;
            end
            6'h05: begin
                d.fn_class = FC_LOGIC; d.logic_fn = LF_XOR; d.use_imm = 1'b1; d.imm_val = zext;
            end
            6'h06: begin
                // NOT x == x NOR 0
                d.fn_class = FC_LOGIC; d.logic_fn = LF_NOR; d.use_imm = 1'b1;
                d.imm_val  = 32'h0000_0000;
            end
            6'h07: begin
                d.fn_class = FC_SLT; d.add_sub = 1'b1; d.use_imm = 1'b1; d.imm_val = sext;
            end
            6'h08: begin
                d.fn_class = FC_SGT; d.add_sub = 1'b1; d.use_imm = 1'b1; d.imm_val = sext;
            end
            6'h09: begin
                d.fn_class = FC_SHIFT; d.shift_fn = SF_SLL; d.use_imm = 1'b1;
                d.imm_val  = {27'd0, instr[4:0]};
            end
            6'h0A: begin
                d.fn_class = FC_SHIFT; d.shift_fn = SF_SRL; d.use_imm = 1'b1;
                d.imm_val  = {27'd0, instr[4:0]};
            end
            6'h0B: begin
                d.fn_class = FC_SHIFT; d.shift_fn = SF_SRA; d.use_imm = 1'b1;
                d.imm_val  = {27'd0, instr[4:0]};
            end
            6'h0C: begin d.fn_class = FC_LUI; d.use_imm = 1'b1; d.imm_val = zext; end
            6'h0D: begin
                d.fn_class = FC_ADD; d.use_imm = 1'b1; d.imm_val = 32'h0000_0001;
            end
            6'h0E: begin
                d.fn_class = FC_ADD; d.add_sub = 1'b1; d.use_imm = 1'b1;
                d.imm_val  = 32'h0000_0001;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    // rs/rt/rd are not needed by this stage; fold them into a sink net
    logic w_unused_bits;
    assign w_unused_bits = ^in_instr;

    logic  [1:0] r_count;
    logic        r_in_ready;
    logic        r_out_valid;
    ctrl_t       r_ent0;     // head of queue, drives the outputs
    ctrl_t       r_ent1;

    logic        w_push;
    logic        w_pop;
    ctrl_t       w_dec;
    logic  [1:0] w_count_nxt;
    ctrl_t       w_ent0_nxt;
    ctrl_t       w_ent1_nxt;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;
    assign w_dec  = decode(in_instr);

    // Next-state for the two-entry FIFO; head is cleared whenever it empties
    always_comb begin
        w_count_nxt = r_count;
        w_ent0_nxt  = r_ent0;
        w_ent1_nxt  = r_ent1;
        if (flush) begin
            w_count_nxt = 2'd0;
            w_ent0_nxt  = CTRL_NONE;
            w_ent1_nxt  = CTRL_NONE;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        w_ent0_nxt  = w_dec;
                        w_count_nxt = 2'd1;
                    end else begin
                        w_ent1_nxt  = w_dec;
                        w_count_nxt = 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        w_ent0_nxt = r_ent1;
                    end else begin
                        w_ent0_nxt = CTRL_NONE;
                    end
                    w_ent1_nxt  = CTRL_NONE;
                    w_count_nxt = r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: replace head, count unchanged
                    w_ent0_nxt = w_dec;
                end
                default: begin
                    w_count_nxt = r_count;
                end
            endcase
        end
    end

    // FIFO state and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ent0      <= CTRL_NONE;
            r_ent1      <= CTRL_NONE;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
            r_ent0      <= w_ent0_nxt;
            r_ent1      <= w_ent1_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign FnClass   = r_ent0.fn_class;
    assign add_sub   = r_ent0.add_sub;
    assign ConstVar  = r_ent0.const_var;
    assign LogicFn   = r_ent0.logic_fn;
    assign ShiftFn   = r_ent0.shift_fn;
    assign use_imm   = r_ent0.use_imm;
    assign imm_val   = r_ent0.imm_val;
    assign illegal   = r_ent0.illegal;

`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [15:0] r_illegal_cnt;

    // Saturating count of illegal bundles consumed by the execute stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= 16'd0;
        end else if (w_pop && r_ent0.illegal && (r_illegal_cnt != 16'hFFFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 16'd1;
        end else begin
            r_illegal_cnt <= r_illegal_cnt;
        end
    end

    assign illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
module tb_alu_ctrl_decoder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  FnClass;
    logic        add_sub;
    logic        ConstVar;
    logic [1:0]  LogicFn;
    logic [1:0]  ShiftFn;
    logic        use_imm;
    logic [31:0] imm_val;
    logic        illegal;
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    int errors = 0;
    int checks = 0;

    alu_ctrl_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .FnClass   (FnClass),
        .add_sub   (add_sub),
        .ConstVar  (ConstVar),
        .LogicFn   (LogicFn),
        .ShiftFn   (ShiftFn),
        .use_imm   (use_imm),
        .imm_val   (imm_val),
        .illegal   (illegal)
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {FnClass, add_sub, ConstVar, LogicFn, ShiftFn, use_imm, illegal}
    function automatic logic [10:0] ctrl_now();
        return {FnClass, add_sub, ConstVar, LogicFn, ShiftFn, use_imm, illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        checks++;
        if (ctrl_now() !== 11'd0 || imm_val !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ctrl=%h imm=%h required 0 0", ctrl_now(), imm_val);
        end
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        checks++;
        if (illegal_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: illegal_cnt=%0d required 0", illegal_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [10:0] ctrl;
        logic [31:0] imm;
    } vec_t;

    task automatic test_decode();
        vec_t v[15];
        v[0]  = '{32'h0000_0000, {3'd3, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0}, 32'h0000_0000}; // ADD
        v[1]  = '{32'h0400_FFFB, {3'd3, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}, 32'hFFFF_FFFB}; // ADDI
        v[2]  = '{32'h0C00_FFFB, {3'd4, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}, 32'h0000_FFFB}; // ANDI
        v[3]  = '{32'h2C00_0024, {3'd5, 1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0}, 32'h0000_0004}; // SRAI
        v[4]  = '{32'h0000_000A, {3'd5, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0}, 32'h0000_0000}; // SRA
        v[5]  = '{32'h0000_0001, {3'd3, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0}, 32'h0000_0000}; // SUB
        v[6]  = '{32'h0000_0005, {3'd4, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0}, 32'h0000_0000}; // NOR
        v[7]  = '{32'h1C00_8000, {3'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}, 32'hFFFF_8000}; // SLTI
        v[8]  = '{32'h3000_8001, {3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}, 32'h0000_8001}; // LUI
        v[9]  = '{32'h1800_1234, {3'd4, 1'b0, 1'b0, 2'd3, 2'd0, 1'b1, 1'b0}, 32'h0000_0000}; // NOT
        v[10] = '{32'h3800_5555, {3'd3, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}, 32'h0000_0001}; // DEC
        v[11] = '{32'h0000_000B, {3'd6, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0}, 32'h0000_0000}; // HAM
        v[12] = '{32'h0000_0007, {3'd2, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0}, 32'h0000_0000}; // SGT
        v[13] = '{32'hFC00_1234, {3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1}, 32'h0000_0000}; // op 3F
        v[14] = '{32'h0000_000C, {3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1}, 32'h0000_0000}; // funct 12
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_instr = v[i].instr;
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dec_hs[%0d]: out_valid=%b in_ready=%b required 1 1", i, out_valid, in_ready);
            end
            checks++;
            if (ctrl_now() !== v[i].ctrl || imm_val !== v[i].imm) begin
                errors++;
                $display("FAIL dec[%0d] instr=%h: ctrl=%b imm=%h required ctrl=%b imm=%h",
                         i, v[i].instr, ctrl_now(), imm_val, v[i].ctrl, v[i].imm);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dec_drain: out_valid=%b required 0", out_valid);
        end
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        checks++;
        if (illegal_cnt !== 16'd2) begin
            errors++;
            $display("FAIL illegal_cnt: got %0d required 2", illegal_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_a;
        logic [10:0] exp_b;
        exp_a = {3'd3, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0}; // ADD
        exp_b = {3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}; // SLLI 3
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000_0000;
        step();
        in_instr = 32'h2400_0003;
        step();
        in_instr = 32'h1400_0007;                           // XORI, must be refused
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || ctrl_now() !== exp_a) begin
            errors++;
            $display("FAIL full: in_ready=%b out_valid=%b ctrl=%b required 0 1 %b",
                     in_ready, out_valid, ctrl_now(), exp_a);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || ctrl_now() !== exp_a || imm_val !== 32'd0) begin
                errors++;
                $display("FAIL stall[%0d]: in_ready=%b out_valid=%b ctrl=%b imm=%h required 0 1 %b 0",
                         k, in_ready, out_valid, ctrl_now(), imm_val, exp_a);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || ctrl_now() !== exp_b || imm_val !== 32'd3) begin
            errors++;
            $display("FAIL pop_order: out_valid=%b in_ready=%b ctrl=%b imm=%h required 1 1 %b 3",
                     out_valid, in_ready, ctrl_now(), imm_val, exp_b);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty: out_valid=%b required 0 (refused entry leaked)", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000_0001;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill: in_ready=%b required 0", in_ready);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1;                 // push in the flush cycle was dropped above
        flush    = 1'b1;
        in_instr = 32'h0000_0003;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_push: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0400_0010;
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ctrl_now() !== 11'd0 || imm_val !== 32'd0) begin
            errors++;
            $display("FAIL async_rst: out_valid=%b in_ready=%b ctrl=%b imm=%h required 0 1 0 0",
                     out_valid, in_ready, ctrl_now(), imm_val);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h3400_0000;       // INC
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || FnClass !== 3'd3 || add_sub !== 1'b0 || imm_val !== 32'd1) begin
            errors++;
            $display("FAIL post_rst: out_valid=%b FnClass=%0d add_sub=%b imm=%h required 1 3 0 1",
                     out_valid, FnClass, add_sub, imm_val);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
